// File: rtl/instr_receive_pkg.sv
// Shared definitions for the instruction transmitter/receiver pair.
package instr_receive_pkg;

    localparam int unsigned DEF_IWIDTH = 32;
    localparam int unsigned DEF_DEPTH  = 7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/instr_ram.sv
// Local instruction RAM: one write port, one registered read port.
// Reads return zero unless the caller allows them and the address is in range.
module instr_ram
    import instr_receive_pkg::*;
#(
    parameter int unsigned IWIDTH = DEF_IWIDTH,
    parameter int unsigned AWIDTH = 3,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic              t_clk,
    input  logic              t_rst,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [IWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    input  logic              allow,
    output logic [IWIDTH-1:0] rdata
);

    localparam logic [AWIDTH:0] DEP = (AWIDTH+1)'(DEPTH);

    logic [IWIDTH-1:0] mem [DEPTH];

    // Storage is never reset so a program survives a receiver reset.
    always_ff @(posedge t_clk) begin
        if (we && ({1'b0, waddr} < DEP)) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; output holds its value when no read is requested.
    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (allow && ({1'b0, raddr} < DEP)) ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/instr_receive.sv
// Instruction receiver: pulls a program from the transmitter into local RAM,
// then serves registered word reads to the fetch stage.
module instr_receive
    import instr_receive_pkg::*;
#(
    parameter int unsigned IWIDTH  = DEF_IWIDTH,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned AWIDTH  = 3,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              t_clk,
    input  logic              t_rst,
    input  logic              i_start,
    output logic              t_o_syn,
    input  logic [IWIDTH-1:0] t_i_instr,
    input  logic              t_i_ack,
    input  logic              t_i_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [AWIDTH:0]   o_count,
    input  logic              i_ren,
    input  logic [AWIDTH-1:0] i_raddr,
    output logic [IWIDTH-1:0] o_rdata,
    output logic              o_rvalid
);

    localparam int unsigned     TW   = $clog2(TIMEOUT + 1);
    localparam logic [AWIDTH:0] FULL = (AWIDTH+1)'(DEPTH);
    localparam logic [TW-1:0]   TLIM = TW'(TIMEOUT - 1);

    state_t          state, state_n;
    logic [AWIDTH:0] count, count_n;
    logic [TW-1:0]   tcnt, tcnt_n;
    logic            we;
    logic            allow;

    // State, word counter and ack-timeout counter registers.
    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            state <= IDLE;
            count <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            tcnt  <= tcnt_n;
        end
    end

    // Next-state, capture and error detection.
    always_comb begin
        state_n = state;
        count_n = count;
        tcnt_n  = tcnt;
        we      = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (i_start) begin
                    state_n = LOAD;
                    count_n = '0;
                    tcnt_n  = '0;
                end
            end
            LOAD: begin
                if (t_i_ack) begin
                    tcnt_n = '0;
                    if (t_i_last) begin
                        if (count < FULL) begin
                            we      = 1'b1;
                            count_n = count + 1'b1;
                        end
                        state_n = FLUSH;
                    end else if (count == FULL) begin
                        state_n = ERR;
                    end else begin
                        we      = 1'b1;
                        count_n = count + 1'b1;
                    end
                end else if (tcnt == TLIM) begin
                    state_n = ERR;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            FLUSH:   state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    assign t_o_syn = (state == LOAD);
    assign o_busy  = (state == LOAD) || (state == FLUSH);
    assign o_done  = (state == DONE);
    assign o_err   = (state == ERR);
    assign o_count = count;
    assign allow   = (state == DONE) && ({1'b0, i_raddr} < count);

    // Read-valid tracks the read enable one cycle later.
    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            o_rvalid <= 1'b0;
        end else begin
            o_rvalid <= i_ren;
        end
    end

    instr_ram #(
        .IWIDTH (IWIDTH),
        .AWIDTH (AWIDTH),
        .DEPTH  (DEPTH)
    ) u_ram (
        .t_clk (t_clk),
        .t_rst (t_rst),
        .we    (we),
        .waddr (count[AWIDTH-1:0]),
        .wdata (t_i_instr),
        .re    (i_ren),
        .raddr (i_raddr),
        .allow (allow),
        .rdata (o_rdata)
    );

endmodule

// File: tb/tb_instr_receive.sv
// Self-checking bench for instr_receive: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_instr_receive;

    localparam int DEPTH   = 7;
    localparam int TIMEOUT = 16;

    logic        t_clk = 1'b0;
    logic        t_rst;
    logic        i_start;
    logic        t_o_syn;
    logic [31:0] t_i_instr;
    logic        t_i_ack;
    logic        t_i_last;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [3:0]  o_count;
    logic        i_ren;
    logic [2:0]  i_raddr;
    logic [31:0] o_rdata;
    logic        o_rvalid;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    instr_receive #(
        .IWIDTH  (32),
        .DEPTH   (DEPTH),
        .AWIDTH  (3),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .t_clk     (t_clk),
        .t_rst     (t_rst),
        .i_start   (i_start),
        .t_o_syn   (t_o_syn),
        .t_i_instr (t_i_instr),
        .t_i_ack   (t_i_ack),
        .t_i_last  (t_i_last),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err     (o_err),
        .o_count   (o_count),
        .i_ren     (i_ren),
        .i_raddr   (i_raddr),
        .o_rdata   (o_rdata),
        .o_rvalid  (o_rvalid)
    );

    always #5 t_clk = ~t_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: program captured so far plus the phase of the load.
    logic [31:0] m_words[$];
    bit          m_load, m_flush, m_done, m_err;
    int          m_idle;
    bit          m_rv;
    logic [31:0] m_rd;

    always @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            m_words.delete();
            m_load = 0; m_flush = 0; m_done = 0; m_err = 0;
            m_idle = 0; m_rv = 0; m_rd = '0;
        end else begin
            if (i_ren) begin
                m_rv = 1;
                m_rd = (m_done && int'(i_raddr) < m_words.size()) ? m_words[i_raddr] : 32'h0;
            end else begin
                m_rv = 0;
            end
            if (m_load) begin
                if (t_i_ack) begin
                    m_idle = 0;
                    if (t_i_last) begin
                        if (m_words.size() < DEPTH) m_words.push_back(t_i_instr);
                        m_load = 0; m_flush = 1;
                    end else if (m_words.size() == DEPTH) begin
                        m_load = 0; m_err = 1;
                    end else begin
                        m_words.push_back(t_i_instr);
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        m_load = 0; m_err = 1;
                    end
                end
            end else if (m_flush) begin
                m_flush = 0; m_done = 1;
            end else if (i_start) begin
                m_words.delete();
                m_load = 1; m_done = 0; m_err = 0; m_idle = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge t_clk) begin
        if (chk_en && t_rst) begin
            check("syn",    t_o_syn,  m_load);
            check("busy",   o_busy,   m_load | m_flush);
            check("done",   o_done,   m_done);
            check("err",    o_err,    m_err);
            check("count",  o_count,  m_words.size());
            check("rvalid", o_rvalid, m_rv);
            check("rdata",  o_rdata,  m_rd);
        end
    end

    task automatic cyc;
        @(posedge t_clk);
        #2;
    endtask

    int target;
    bit slow;

    initial begin
        t_rst = 0; i_start = 0; t_i_instr = '0; t_i_ack = 0; t_i_last = 0;
        i_ren = 0; i_raddr = '0;
        #3;
        check("rst_syn",    t_o_syn,  0);
        check("rst_busy",   o_busy,   0);
        check("rst_done",   o_done,   0);
        check("rst_err",    o_err,    0);
        check("rst_count",  o_count,  0);
        check("rst_rdata",  o_rdata,  0);
        check("rst_rvalid", o_rvalid, 0);
        @(posedge t_clk); @(posedge t_clk); #2;
        t_rst = 1; chk_en = 1;

        // Nominal load of seven words.
        i_start = 1; cyc; i_start = 0;
        #1 check("nom_syn_up", t_o_syn, 1);
        for (int i = 0; i < 7; i++) begin
            t_i_ack = 1; t_i_instr = 32'h20080005 + i; t_i_last = (i == 6);
            cyc;
        end
        t_i_ack = 0; t_i_last = 0;
        #1 check("nom_syn_down", t_o_syn, 0);
        check("nom_flush_busy", o_busy, 1);
        check("nom_not_done", o_done, 0);
        cyc;
        #1 check("nom_done", o_done, 1);
        check("nom_count", o_count, 7);

        // Back-to-back readback, then one out-of-range address.
        for (int i = 0; i < 8; i++) begin
            i_ren = 1; i_raddr = 3'(i);
            cyc;
            #1 check("rb_valid", o_rvalid, 1);
            check("rb_data", o_rdata, (i < 7) ? 32'h20080005 + i : 32'h0);
        end
        i_ren = 0; cyc;
        #1 check("rb_valid_low", o_rvalid, 0);
        check("rb_hold", o_rdata, 0);

        // Reload from DONE with a trailing ack past the last word.
        i_start = 1; cyc; i_start = 0;
        #1 check("rl_done_low", o_done, 0);
        check("rl_count0", o_count, 0);
        check("rl_syn", t_o_syn, 1);
        for (int i = 0; i < 8; i++) begin
            t_i_ack = 1; t_i_instr = 32'h10000000 + i; t_i_last = (i == 6);
            cyc;
        end
        t_i_ack = 0; t_i_last = 0;
        cyc;
        #1 check("tr_done", o_done, 1);
        check("tr_count", o_count, 7);
        i_ren = 1; i_raddr = 3'd6; cyc; i_ren = 0;
        #1 check("tr_word6", o_rdata, 32'h10000006);

        // Overflow: eight acks, none flagged last.
        i_start = 1; cyc; i_start = 0;
        for (int i = 0; i < 8; i++) begin
            t_i_ack = 1; t_i_instr = 32'h30000000 + i; t_i_last = 0;
            cyc;
        end
        t_i_ack = 0;
        #1 check("ov_err", o_err, 1);
        check("ov_count", o_count, 7);
        check("ov_syn", t_o_syn, 0);

        // Timeout: sixteen cycles in LOAD without an ack.
        i_start = 1; cyc; i_start = 0;
        #1 check("to_err_clear", o_err, 0);
        check("to_syn", t_o_syn, 1);
        for (int k = 1; k < 16; k++) cyc;
        #1 check("to_err_early", o_err, 0);
        cyc;
        #1 check("to_err", o_err, 1);
        check("to_syn_low", t_o_syn, 0);
        i_start = 1; cyc; i_start = 0;
        #1 check("to_restart_err", o_err, 0);
        check("to_restart_syn", t_o_syn, 1);

        // Asynchronous reset after three captured words.
        for (int i = 0; i < 3; i++) begin
            t_i_ack = 1; t_i_instr = 32'h40000000 + i; t_i_last = 0;
            cyc;
        end
        t_i_ack = 0;
        #1 check("mr_count3", o_count, 3);
        #1 t_rst = 0;
        #1 check("mr_syn", t_o_syn, 0);
        check("mr_busy", o_busy, 0);
        check("mr_count", o_count, 0);
        #2 t_rst = 1;
        i_ren = 1; i_raddr = 3'd0; cyc; i_ren = 0;
        #1 check("mr_rvalid", o_rvalid, 1);
        check("mr_rdata", o_rdata, 0);
        check("mr_idle_done", o_done, 0);
        check("mr_idle_busy", o_busy, 0);

        // Randomized traffic against the model.
        target = 0; slow = 0;
        for (int n = 0; n < 4000; n++) begin
            i_ren   = 1'($urandom % 2);
            i_raddr = 3'($urandom % 8);
            if (!m_load && !m_flush && ($urandom % 6 == 0)) begin
                i_start = 1;
                target  = $urandom_range(0, DEPTH);
                slow    = ($urandom % 5 == 0);
            end else begin
                i_start = ($urandom % 30 == 0);
            end
            t_i_ack   = slow ? ($urandom % 25 == 0) : ($urandom % 3 != 0);
            t_i_instr = $urandom;
            if (m_load)
                t_i_last = t_i_ack && (target != 0) && (m_words.size() + 1 == target);
            else
                t_i_last = 1'($urandom % 2);
            cyc;
        end
        i_start = 0; t_i_ack = 0; t_i_last = 0; i_ren = 0;
        cyc;
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_receive.md
Name: instr_receive

Overview:
- Downstream consumer of the instruction transmitter.
- Requests instructions by holding the sync line, captures each acknowledged word into a local instruction RAM, and stops after the word flagged last.
- After loading, serves registered word reads to the MIPS fetch stage.
- Flags overflow and handshake timeout errors.

Parameters:
- IWIDTH, 32, instruction word width.
- DEPTH, 7, number of RAM words; equals the transmitter program length.
- AWIDTH, 3, RAM address width; must satisfy 2**AWIDTH >= DEPTH.
- TIMEOUT, 16, maximum cycles in LOAD without an ack before error.

Ports:
- t_clk  input  1  clock, rising edge.
- t_rst  input  1  asynchronous active-low reset.
- i_start  input  1  single-cycle pulse to begin a load.
- t_o_syn  output  1  request to transmitter; high while loading.
- t_i_instr  input  IWIDTH  word from transmitter.
- t_i_ack  input  1  t_i_instr valid this cycle.
- t_i_last  input  1  qualifies the final word; meaningful only with t_i_ack.
- o_busy  output  1  high in LOAD and FLUSH.
- o_done  output  1  high in DONE; program resident.
- o_err  output  1  sticky error; high in ERR.
- o_count  output  AWIDTH+1  number of words captured.
- i_ren  input  1  read enable from fetch.
- i_raddr  input  AWIDTH  word address to read.
- o_rdata  output  IWIDTH  read data, registered.
- o_rvalid  output  1  o_rdata valid, one cycle after i_ren.

Behaviour:
- Reset: t_rst low forces, asynchronously, state=IDLE, t_o_syn=0, o_busy=0, o_done=0, o_err=0, o_count=0, o_rdata=0, o_rvalid=0, timeout counter=0. RAM contents are not cleared. Reset mid-load abandons the load immediately.
- States: IDLE, LOAD, FLUSH, DONE, ERR.
- IDLE:
  - i_start -> LOAD next cycle; o_count<=0; t_o_syn<=1.
  - t_i_ack is ignored.
- LOAD:
  - t_o_syn=1.
  - Each cycle with t_i_ack=1: RAM[o_count]<=t_i_instr; o_count<=o_count+1; timeout counter cleared.
  - t_i_ack=1 and t_i_last=1: word is written, then -> FLUSH with t_o_syn<=0. syn falls on the clock edge after the last ack.
  - t_i_ack=1 with o_count==DEPTH and t_i_last=0: overflow. No write; -> ERR; t_o_syn<=0.
  - No ack: timeout counter increments. When it reaches TIMEOUT-1 with no ack -> ERR; t_o_syn<=0.
  - i_start is ignored in LOAD.
- FLUSH:
  - One cycle; any t_i_ack present is ignored (absorbs a trailing transmitter ack).
  - -> DONE.
- DONE:
  - o_done=1.
  - i_start -> LOAD (reload), o_count<=0, o_done falls next cycle.
- ERR:
  - o_err=1; t_o_syn=0.
  - Exit only via i_start: -> LOAD, clearing o_err and o_count.
- o_busy=1 exactly in LOAD and FLUSH.
- Read port, active in every state:
  - i_ren=1 -> next cycle o_rvalid=1.
  - o_rdata=RAM[i_raddr] if state==DONE and i_raddr<o_count, else 0.
  - i_ren=0 -> o_rvalid=0 next cycle; o_rdata holds its value.
  - Back-to-back reads give one result per cycle.
- Write and read of the same address in the same cycle cannot occur, because reads return 0 outside DONE.
- o_count is at most DEPTH; widths are exact, with no wrap.

Decomposition:
- Shared package: state encoding constants (IDLE=0, LOAD=1, FLUSH=2, DONE=3, ERR=4) and the default IWIDTH and DEPTH values, shared with the transmitter.
- One sub-module: instr_ram. Single write port, single registered read port, parameterised by IWIDTH/AWIDTH/DEPTH.
- The FSM, counters and error logic stay in instr_receive.

Test Plan:
- Nominal load:
  - Stimulus: reset, pulse i_start; transmitter model returns 7 acked words 0x20080005..0x2008000B, t_i_last on the 7th.
  - Required: t_o_syn high from the cycle after start until the edge after the last ack; o_done=1 two cycles after the last ack; o_count=7.
- Readback:
  - Stimulus: after the nominal load, i_ren on addresses 0..6 back-to-back.
  - Required: o_rvalid high for 7 cycles, o_rdata=0x20080005..0x2008000B in order; i_raddr=7 returns 0.
- Overflow:
  - Stimulus: DEPTH=7, send 8 acks with no t_i_last.
  - Required: o_err=1 on the cycle after the 8th ack; o_count=7; RAM word 6 intact; t_o_syn=0.
- Timeout:
  - Stimulus: i_start, then no ack for 16 cycles.
  - Required: o_err=1 and t_o_syn=0 at cycle 16 after LOAD entry; a later i_start clears o_err and re-raises t_o_syn.
- Trailing ack and reload:
  - Stimulus: hold the ack one cycle past last.
  - Required: extra word not written, o_count=7.
  - Stimulus: pulse i_start in DONE.
  - Required: o_done falls, o_count=0, fresh load completes.
- Reset mid-load:
  - Stimulus: assert t_rst after 3 acks, asynchronously between clock edges.
  - Required: t_o_syn, o_busy, o_count drop to 0 immediately; state IDLE; reads return 0.
